// File: rtl/idx_alloc_bitmap.sv
// Lowest-free index allocator over a 2**IDX_W entry bitmap with zero-latency grant.
// Optional macro ALLOC_RR_EN switches the search to round-robin from a rotating pointer.
module idx_alloc_bitmap #(
    parameter int IDX_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alloc_req,
    output logic                    alloc_gnt,
    output logic [IDX_W-1:0]        alloc_idx,
    input  logic                    free_valid,
    input  logic [IDX_W-1:0]        free_idx,
    output logic [(2**IDX_W)-1:0]   used_map,
    output logic [IDX_W:0]          used_cnt,
    output logic                    full,
    output logic                    empty,
    output logic                    free_err
);

    localparam int ENTRIES = 2**IDX_W;
    localparam logic [IDX_W:0] FULL_CNT = ENTRIES[IDX_W:0];

    logic [ENTRIES-1:0] used_map_r;
    logic [ENTRIES-1:0] used_map_next_s;
    logic [IDX_W:0]     used_cnt_r;
    logic [IDX_W:0]     used_cnt_next_s;
    logic               free_err_r;
    logic               free_err_next_s;
    logic [IDX_W-1:0]   search_start_s;
    logic [IDX_W-1:0]   found_idx_s;
    logic [ENTRIES-1:0] set_mask_s;
    logic [ENTRIES-1:0] clr_mask_s;
    logic               full_s;
    logic               gnt_s;
    logic               free_legal_s;

    // First clear bit at or above start, wrapping; returns 0 if none is clear.
    function automatic logic [IDX_W-1:0] find_free(
        input logic [ENTRIES-1:0] map,
        input logic [IDX_W-1:0]   start
    );
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] idx;
        logic             found;
        res   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            idx = start + IDX_W'(k);
            if (!found && !map[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    // IDX_W-to-ENTRIES one-hot decode.
    function automatic logic [ENTRIES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [ENTRIES-1:0] v;
        v      = {ENTRIES{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef ALLOC_RR_EN
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] rr_ptr_next_s;

    // Pointer advances past each granted index; natural IDX_W wrap gives modulo ENTRIES.
    always_comb begin
        rr_ptr_next_s = rr_ptr_r;
        if (gnt_s) begin
            rr_ptr_next_s = alloc_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            rr_ptr_next_s = rr_ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

    assign search_start_s = rr_ptr_r;
`else
    assign search_start_s = {IDX_W{1'b0}};
`endif

    assign full_s      = (used_cnt_r == FULL_CNT);
    assign found_idx_s = find_free(used_map_r, search_start_s);

    // Grant, masks and next-state; grant always sees pre-edge state so a freed slot waits a cycle.
    always_comb begin
        gnt_s           = 1'b0;
        alloc_idx       = {IDX_W{1'b0}};
        set_mask_s      = {ENTRIES{1'b0}};
        clr_mask_s      = {ENTRIES{1'b0}};
        free_legal_s    = 1'b0;
        free_err_next_s = 1'b0;
        if (full_s) begin
            alloc_idx = {IDX_W{1'b0}};
            gnt_s     = 1'b0;
        end else begin
            alloc_idx = found_idx_s;
            gnt_s     = alloc_req;
        end
        if (gnt_s) begin
            set_mask_s = onehot(alloc_idx);
        end else begin
            set_mask_s = {ENTRIES{1'b0}};
        end
        if (free_valid) begin
            free_legal_s    = used_map_r[free_idx];
            free_err_next_s = ~used_map_r[free_idx];
        end else begin
            free_legal_s    = 1'b0;
            free_err_next_s = 1'b0;
        end
        if (free_legal_s) begin
            clr_mask_s = onehot(free_idx);
        end else begin
            clr_mask_s = {ENTRIES{1'b0}};
        end
        used_map_next_s = (used_map_r | set_mask_s) & ~clr_mask_s;
        used_cnt_next_s = used_cnt_r + {{IDX_W{1'b0}}, gnt_s}
                                     - {{IDX_W{1'b0}}, free_legal_s};
    end

    // Bitmap, population count and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            used_map_r <= {ENTRIES{1'b0}};
            used_cnt_r <= {(IDX_W+1){1'b0}};
            free_err_r <= 1'b0;
        end else begin
            used_map_r <= used_map_next_s;
            used_cnt_r <= used_cnt_next_s;
            free_err_r <= free_err_next_s;
        end
    end

    assign alloc_gnt = gnt_s;
    assign used_map  = used_map_r;
    assign used_cnt  = used_cnt_r;
    assign full      = full_s;
    assign empty     = (used_cnt_r == {(IDX_W+1){1'b0}});
    assign free_err  = free_err_r;

endmodule

// File: doc/idx_alloc_bitmap.md
# idx_alloc_bitmap

Parametrised index allocator for the CPU core. It keeps a bitmap of 2^IDX_W entries and hands out the lowest free index on request. Each allocated index's bit is set, and freeing an index clears its bit, through an internal IDX_W-to-2^IDX_W one-hot decode. Typical clients are TLB-entry replacement, miss-buffer slots and store-buffer tags, which need a free index in the same cycle they ask.

## Interface
Parameters:
- IDX_W, default 5: index width.
  - ENTRIES = 2**IDX_W is a derived localparam.
  - Legal range is 1..6.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- alloc_req, input, 1: request one index this cycle.
- alloc_gnt, output, 1: grant. Combinational, equals alloc_req & ~full.
- alloc_idx, output, IDX_W: index granted.
  - Combinational from registered state.
  - Valid whenever ~full; reads 0 when full.
- free_valid, input, 1: release free_idx this cycle.
- free_idx, input, IDX_W: index to release.
- used_map, output, ENTRIES: registered bitmap. Bit i = 1 means entry i is allocated.
- used_cnt, output, IDX_W+1: registered population count of used_map.
- full, output, 1: used_cnt == ENTRIES, registered-derived.
- empty, output, 1: used_cnt == 0, registered-derived.
- free_err, output, 1: registered one-cycle pulse when a free targets an unallocated entry.

## Operation
- Reset values:
  - used_map = 0, used_cnt = 0, free_err = 0.
  - Hence empty = 1, full = 0, alloc_idx = 0.
- Search:
  - alloc_idx is the lowest i with used_map[i] == 0.
  - It is a priority encode over ~used_map.
- Alloc:
  - When alloc_gnt = 1, bit alloc_idx is set at the next edge.
  - alloc_req while full gives no grant, no state change and no error.
- Free:
  - When free_valid = 1 and used_map[free_idx] == 1, that bit is cleared at the next edge.
  - When free_valid = 1 and the bit is already 0, the bitmap is unchanged and free_err = 1 in the next cycle.
- Simultaneous alloc and free in one cycle:
  - Both take effect at the same edge.
  - The set mask and clear mask are decoded independently. The next bitmap is (used_map | set_onehot) & ~clr_onehot.
  - They never target the same bit: a legal free names a used bit, and alloc_idx is always unused.
  - A freed entry is not re-grantable in the same cycle; the grant uses pre-edge state.
  - Full plus free: no grant this cycle; the freed entry is available next cycle.
- Count:
  - used_cnt_next = used_cnt + alloc_gnt − (legal free).
  - Width IDX_W+1 holds ENTRIES exactly; no wrap is possible.
- Reset asserted mid-operation clears all state immediately, regardless of in-flight requests.

## Timing
- Allocation is zero-latency: alloc_gnt and alloc_idx are valid in the request cycle.
- used_map, used_cnt, full and empty reflect an alloc or free one cycle later.
- free_err is a one-cycle pulse in the cycle after the offending free.
  - Back-to-back bad frees give consecutive pulses.
- There is no backpressure on free. A free is always accepted in the cycle presented.

## Configuration
- ALLOC_RR_EN, when defined:
  - Adds a registered pointer rr_ptr (IDX_W bits, reset 0).
  - alloc_idx becomes the first free index at or above rr_ptr, wrapping modulo ENTRIES.
  - On each grant, rr_ptr <= alloc_idx + 1, wrapping from ENTRIES−1 to 0.
  - rr_ptr is unchanged by frees.
- ALLOC_RR_EN undefined:
  - Fixed lowest-index priority.
  - No pointer register exists.

## Test plan
- Reset then idle: used_map = 0, used_cnt = 0, empty = 1, full = 0, alloc_idx = 0, free_err = 0.
- Fill, IDX_W = 5: alloc_req held 32 cycles.
  - Grants return indices 0..31 in order.
  - full = 1 after the 32nd edge, used_map = 0xFFFF_FFFF.
  - A 33rd request gives alloc_gnt = 0.
- Full plus free 7 plus alloc_req in the same cycle:
  - No grant that cycle.
  - Next cycle used_cnt = 31, alloc_idx = 7, grant succeeds.
- Holes: allocate 0..3, then free 1 and free 2 on separate cycles.
  - alloc_idx = 1.
  - Next grant returns 1, then 2, then 4.
- Bad free: free_idx = 9 while used_map[9] = 0.
  - free_err = 1 for exactly one cycle.
  - Bitmap and count unchanged.
- ALLOC_RR_EN: allocate 0, 1, free 0, then request.
  - Grant returns 2, not 0.
  - After wrapping past 31, returns 0.
